// File: rtl/rsa_modexp_core.sv
// Constant-time right-to-left square-and-multiply modular exponentiation.
// A shared multiplier feeds a bit-serial restoring reducer, so every operation costs 2W+1 cycles.
module rsa_modexp_core #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] msg,
    input  logic [W-1:0] key_e,
    input  logic [W-1:0] mod_n,
    output logic [W-1:0] data_out,
    output logic         Done,
    output logic         busy,
    output logic         err
);

    localparam int PW = 2 * W;
    localparam int CW = $clog2(PW + 1);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [3:0] {
        IDLE, CHECK, PRE, MUL_R, RED_R, MUL_B, RED_B, NEXT, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  msg_q, msg_d;
    logic [W-1:0]  e_q, e_d;
    logic [W-1:0]  n_q, n_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  base_q, base_d;
    logic [PW-1:0] p_q, p_d;
    logic [W-1:0]  r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  data_out_q, data_out_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          bad_q, bad_d;

    logic [W-1:0]  op_a, op_b;
    logic [PW-1:0] prod;
    logic [W:0]    r_shift;
    logic [W-1:0]  rem;
    logic          red_last;

    // Datapath: operand select, full-width product and one restoring reduction step.
    always_comb begin
        op_a = base_q;
        op_b = base_q;
        case (state_q)
            PRE:     begin op_a = W'(1); op_b = msg_q;  end
            MUL_R:   begin op_a = acc_q; op_b = base_q; end
            default: begin op_a = base_q; op_b = base_q; end
        endcase
        prod     = PW'(op_a) * PW'(op_b);
        r_shift  = {r_q, p_q[PW-1]};
        rem      = (r_shift >= {1'b0, n_q}) ? W'(r_shift - {1'b0, n_q}) : r_shift[W-1:0];
        red_last = (cnt_q == CW'(PW));
    end

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        e_d        = e_q;
        n_d        = n_q;
        acc_d      = acc_q;
        base_d     = base_q;
        p_d        = p_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_out_d = data_out_q;
        done_d     = done_q;
        busy_d     = busy_q;
        err_d      = err_q;
        bad_d      = bad_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    msg_d   = msg;
                    e_d     = key_e;
                    n_d     = mod_n;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    bad_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (n_q == '0) begin
                    // Invalid modulus spends a second cycle here so err always lands two edges after accept.
                    if (bad_q) begin
                        data_out_d = '0;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        err_d      = 1'b1;
                        bad_d      = 1'b0;
                        state_d    = DONE;
                    end else begin
                        bad_d = 1'b1;
                    end
                end else begin
                    // Accumulator starts at 1 mod n, which is 0 when n is 1.
                    acc_d   = (n_q == W'(1)) ? '0 : W'(1);
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = PRE;
                end
            end
            PRE: begin
                if (cnt_q == '0) begin
                    p_d   = prod;
                    r_d   = '0;
                    cnt_d = CW'(1);
                end else begin
                    p_d   = p_q << 1;
                    r_d   = rem;
                    cnt_d = cnt_q + CW'(1);
                    if (red_last) begin
                        base_d  = rem;
                        state_d = MUL_R;
                    end
                end
            end
            MUL_R, MUL_B: begin
                p_d     = prod;
                r_d     = '0;
                cnt_d   = CW'(1);
                state_d = (state_q == MUL_R) ? RED_R : RED_B;
            end
            RED_R: begin
                p_d   = p_q << 1;
                r_d   = rem;
                cnt_d = cnt_q + CW'(1);
                // Product is always computed; only the commit depends on the key bit.
                if (red_last) begin
                    if (e_q[idx_q]) begin
                        acc_d = rem;
                    end
                    state_d = MUL_B;
                end
            end
            RED_B: begin
                p_d   = p_q << 1;
                r_d   = rem;
                cnt_d = cnt_q + CW'(1);
                if (red_last) begin
                    base_d = rem;
                    if (idx_q == IW'(W - 1)) begin
                        data_out_d = acc_q;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        err_d      = 1'b0;
                        state_d    = DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = MUL_R;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            msg_q      <= '0;
            e_q        <= '0;
            n_q        <= '0;
            acc_q      <= '0;
            base_q     <= '0;
            p_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            e_q        <= e_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            base_q     <= base_d;
            p_q        <= p_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            bad_q      <= bad_d;
        end
    end

    assign data_out = data_out_q;
    assign Done     = done_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed and random checks of rsa_modexp_core: results, fixed latency, err path,
// ignored restarts and mid-operation reset.
module tb_rsa_modexp_core;

    localparam int LAT = 170;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] msg, key_e, mod_n;
    logic [5:0] data_out;
    logic       Done, busy, err;

    int checks = 0;
    int errors = 0;

    rsa_modexp_core #(.W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msg(msg), .key_e(key_e),
        .mod_n(mod_n), .data_out(data_out), .Done(Done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Reference by repeated multiplication, independent of the bit-serial algorithm.
    function automatic int ref_modpow(input int b, input int e, input int n);
        int r;
        r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return r;
    endfunction

    // Drives one start and measures edges from acceptance until Done (bounded).
    task automatic run_op(input logic [5:0] m, input logic [5:0] e, input logic [5:0] n,
                          output logic a_busy, output logic a_done,
                          output logic [5:0] a_data, output int lat);
        @(negedge clk);
        msg = m; key_e = e; mod_n = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_busy = busy; a_done = Done; a_data = data_out;
        lat = 0;
        while (Done !== 1'b1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; msg = 6'd4; key_e = 6'd3; mod_n = 6'd33;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({Done, busy, err, data_out} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b expected 0", {Done, busy, err, data_out});
        end
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wins_start busy got %b expected 0", busy);
        end
    endtask

    task automatic test_basic;
        logic ab, ad; logic [5:0] adata; int lat;
        run_op(6'd4, 6'd3, 6'd33, ab, ad, adata, lat);
        checks++;
        if (ab !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b expected 1", ab); end
        checks++;
        if (lat !== LAT) begin errors++; $display("[TB] FAIL basic_latency got %0d expected %0d", lat, LAT); end
        checks++;
        if (data_out !== 6'd31 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_result got %0d err %b expected 31 err 0", data_out, err);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (Done !== 1'b1 || data_out !== 6'd31 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_hold cycle %0d got Done %b data %0d busy %b expected 1 31 0",
                         i, Done, data_out, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic ab, ad; logic [5:0] adata; int lat;
        run_op(6'd31, 6'd7, 6'd33, ab, ad, adata, lat);
        checks++;
        if (ad !== 1'b0 || ab !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_accept got Done %b busy %b expected 0 1", ad, ab);
        end
        checks++;
        if (adata !== 6'd31) begin errors++; $display("[TB] FAIL b2b_old_data got %0d expected 31", adata); end
        checks++;
        if (lat !== LAT) begin errors++; $display("[TB] FAIL b2b_latency got %0d expected %0d", lat, LAT); end
        checks++;
        if (data_out !== 6'd4) begin errors++; $display("[TB] FAIL b2b_result got %0d expected 4", data_out); end
    endtask

    task automatic test_boundaries;
        logic [5:0] vm[5] = '{6'd40, 6'd10, 6'd9, 6'd0, 6'd9};
        logic [5:0] ve[5] = '{6'd1,  6'd0,  6'd5, 6'd5, 6'd0};
        logic [5:0] vn[5] = '{6'd33, 6'd33, 6'd1, 6'd33, 6'd1};
        logic [5:0] vx[5] = '{6'd7,  6'd1,  6'd0, 6'd0, 6'd0};
        logic ab, ad; logic [5:0] adata; int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(vm[i], ve[i], vn[i], ab, ad, adata, lat);
            checks++;
            if (lat !== LAT) begin
                errors++; $display("[TB] FAIL boundary_%0d_latency got %0d expected %0d", i, lat, LAT);
            end
            checks++;
            if (data_out !== vx[i] || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL boundary_%0d_result got %0d err %b expected %0d err 0",
                         i, data_out, err, vx[i]);
            end
        end
    endtask

    task automatic test_invalid_mod;
        logic ab, ad; logic [5:0] adata; int lat;
        run_op(6'd5, 6'd3, 6'd0, ab, ad, adata, lat);
        checks++;
        if (ab !== 1'b1) begin errors++; $display("[TB] FAIL badmod_busy got %b expected 1", ab); end
        checks++;
        if (lat !== 2) begin errors++; $display("[TB] FAIL badmod_latency got %0d expected 2", lat); end
        checks++;
        if (err !== 1'b1 || data_out !== 6'd0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL badmod_result got err %b data %0d busy %b expected 1 0 0", err, data_out, busy);
        end
        run_op(6'd4, 6'd3, 6'd33, ab, ad, adata, lat);
        checks++;
        if (err !== 1'b0 || data_out !== 6'd31 || lat !== LAT) begin
            errors++;
            $display("[TB] FAIL badmod_recover got err %b data %0d lat %0d expected 0 31 %0d",
                     err, data_out, lat, LAT);
        end
    endtask

    task automatic test_start_ignored;
        int lat;
        @(negedge clk);
        msg = 6'd4; key_e = 6'd3; mod_n = 6'd33; start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (Done !== 1'b1 && lat < 400) begin
            @(negedge clk);
            if (lat == 49) begin
                start = 1'b1; msg = 6'd7; key_e = 6'd2; mod_n = 6'd11;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat !== LAT || data_out !== 6'd31) begin
            errors++;
            $display("[TB] FAIL start_ignored got lat %0d data %0d expected %0d 31", lat, data_out, LAT);
        end
    endtask

    task automatic test_reset_mid;
        logic ab, ad; logic [5:0] adata; int lat;
        @(negedge clk);
        msg = 6'd4; key_e = 6'd3; mod_n = 6'd33; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (79) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({Done, busy, err, data_out} !== 9'b0) begin
            errors++; $display("[TB] FAIL midreset_outputs got %b expected 0", {Done, busy, err, data_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(6'd5, 6'd3, 6'd33, ab, ad, adata, lat);
        checks++;
        if (ab !== 1'b1 || lat !== LAT || data_out !== 6'd26) begin
            errors++;
            $display("[TB] FAIL midreset_restart got busy %b lat %0d data %0d expected 1 %0d 26",
                     ab, lat, data_out, LAT);
        end
    endtask

    task automatic test_random_sweep;
        logic ab, ad; logic [5:0] adata; int lat;
        logic [5:0] m, e, n; int expv;
        for (int i = 0; i < 200; i++) begin
            m = 6'($urandom_range(0, 63));
            e = 6'($urandom_range(0, 63));
            n = 6'($urandom_range(2, 63));
            expv = ref_modpow(int'(m), int'(e), int'(n));
            run_op(m, e, n, ab, ad, adata, lat);
            checks++;
            if (lat !== LAT) begin
                errors++; $display("[TB] FAIL sweep_%0d_latency got %0d expected %0d", i, lat, LAT);
            end
            checks++;
            if (int'(data_out) !== expv) begin
                errors++;
                $display("[TB] FAIL sweep_%0d_result %0d^%0d mod %0d got %0d expected %0d",
                         i, m, e, n, data_out, expv);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_boundaries;
        test_invalid_mod;
        test_start_ignored;
        test_reset_mid;
        test_random_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
